// File: rtl/riscv_cpu_pkg.sv
// Shared riscv_cpu types and constants used by the hazard controller:
// forwarding-select encoding, hazard FSM states and scoreboard entry layout.
package riscv_cpu_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int FWD_SEL_WIDTH  = 2;

    localparam logic [FWD_SEL_WIDTH-1:0] FWD_NONE  = 2'd0;
    localparam logic [FWD_SEL_WIDTH-1:0] FWD_EXMEM = 2'd1;
    localparam logic [FWD_SEL_WIDTH-1:0] FWD_MEMWB = 2'd2;

    typedef enum logic {
        HZ_RUN,
        HZ_WAIT_MEM
    } hazard_state_e;

    typedef struct packed {
        logic                      valid;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      we;
        logic                      load;
    } sb_entry_t;

    localparam int SB_ENTRY_W = $bits(sb_entry_t);

    // True when an in-flight producer writes the register that ID reads; x0 never matches.
    function automatic logic rd_hit(input sb_entry_t e,
                                    input logic [REG_ADDR_WIDTH-1:0] rs,
                                    input logic used);
        return used & e.valid & e.we & (e.rd != '0) & (e.rd == rs);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Shadow scoreboard of in-flight destinations (EX, MEM, WB); holds while frozen,
// loads an invalid EX entry when a bubble or flush is inserted.
module hazard_scoreboard
    import riscv_cpu_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  freeze_i,
    input  logic                  bubble_i,
    input  logic [SB_ENTRY_W-1:0] id_entry_i,
    output logic [SB_ENTRY_W-1:0] ex_entry_o,
    output logic [SB_ENTRY_W-1:0] mem_entry_o,
    output logic [SB_ENTRY_W-1:0] wb_entry_o
);

    localparam int PAY_W = SB_ENTRY_W - 1;

    sb_entry_t        id_e;
    logic             ex_vld_p0, mem_vld_p1, wb_vld_p2;
    logic [PAY_W-1:0] ex_pay_p0, mem_pay_p1, wb_pay_p2;

    assign id_e = sb_entry_t'(id_entry_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_vld_p0  <= 1'b0;
            mem_vld_p1 <= 1'b0;
            wb_vld_p2  <= 1'b0;
        end else if (!freeze_i) begin
            ex_vld_p0  <= id_e.valid & ~bubble_i;
            mem_vld_p1 <= ex_vld_p0;
            wb_vld_p2  <= mem_vld_p1;
        end
    end

    // Payload is qualified by the valid bits, so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (!freeze_i) begin
            ex_pay_p0  <= {id_e.rd, id_e.we, id_e.load};
            mem_pay_p1 <= ex_pay_p0;
            wb_pay_p2  <= mem_pay_p1;
        end
    end

    assign ex_entry_o  = {ex_vld_p0,  ex_pay_p0};
    assign mem_entry_o = {mem_vld_p1, mem_pay_p1};
    assign wb_entry_o  = {wb_vld_p2,  wb_pay_p2};

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage riscv_cpu core: freeze, redirect flush, load-use/RAW
// stalls, registered forwarding selects. Define HAZARD_CTRL_FWD_EN to enable forwarding.
module hazard_ctrl
    import riscv_cpu_pkg::*;
#(
    parameter int ADDR_WIDTH  = REG_ADDR_WIDTH,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  id_valid_i,
    input  logic [ADDR_WIDTH-1:0] id_rs1_i,
    input  logic [ADDR_WIDTH-1:0] id_rs2_i,
    input  logic                  id_rs1_used_i,
    input  logic                  id_rs2_used_i,
    input  logic [ADDR_WIDTH-1:0] id_rd_i,
    input  logic                  id_reg_we_i,
    input  logic                  id_load_i,
    input  logic                  ex_redirect_i,
    input  logic                  mem_req_i,
    input  logic                  mem_ready_i,
    output logic                  pc_stall_o,
    output logic                  if_id_stall_o,
    output logic                  if_id_flush_o,
    output logic                  id_ex_flush_o,
    output logic                  pipe_freeze_o,
    output logic [1:0]            fwd_a_sel_o,
    output logic [1:0]            fwd_b_sel_o,
    output logic                  mem_timeout_o
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    logic [SB_ENTRY_W-1:0] id_entry, ex_entry, mem_entry, wb_entry;
    sb_entry_t             ex_e, mem_e;
    logic                  freeze, redirect, bubble, stall, load_use;
    logic                  hit_ex_a, hit_ex_b, hit_mem_a, hit_mem_b;

    hazard_scoreboard u_scoreboard (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .freeze_i   (freeze),
        .bubble_i   (bubble),
        .id_entry_i (id_entry),
        .ex_entry_o (ex_entry),
        .mem_entry_o(mem_entry),
        .wb_entry_o (wb_entry)
    );

    assign id_entry = {id_valid_i, id_rd_i, id_reg_we_i, id_load_i};
    assign ex_e     = sb_entry_t'(ex_entry);
    assign mem_e    = sb_entry_t'(mem_entry);

    // Outputs must drop the moment reset asserts, even with a live memory wait.
    assign freeze   = rst_ni & mem_req_i & ~mem_ready_i;
    assign redirect = rst_ni & ex_redirect_i;

    assign hit_ex_a  = id_valid_i & rd_hit(ex_e,  id_rs1_i, id_rs1_used_i);
    assign hit_ex_b  = id_valid_i & rd_hit(ex_e,  id_rs2_i, id_rs2_used_i);
    assign hit_mem_a = id_valid_i & rd_hit(mem_e, id_rs1_i, id_rs1_used_i);
    assign hit_mem_b = id_valid_i & rd_hit(mem_e, id_rs2_i, id_rs2_used_i);
    assign load_use  = ex_e.load & (hit_ex_a | hit_ex_b);

`ifdef HAZARD_CTRL_FWD_EN
    assign stall = load_use;
`else
    assign stall = load_use | hit_ex_a | hit_ex_b | hit_mem_a | hit_mem_b;
`endif

    assign bubble = redirect | stall;

    always_comb begin
        pc_stall_o    = 1'b0;
        if_id_stall_o = 1'b0;
        if_id_flush_o = 1'b0;
        id_ex_flush_o = 1'b0;
        pipe_freeze_o = 1'b0;
        if (freeze) begin
            pipe_freeze_o = 1'b1;
            pc_stall_o    = 1'b1;
            if_id_stall_o = 1'b1;
        end else if (redirect) begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end else if (stall) begin
            pc_stall_o    = 1'b1;
            if_id_stall_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end
    end

`ifdef HAZARD_CTRL_FWD_EN
    logic [1:0] fwd_a_d, fwd_b_d, fwd_a_q, fwd_b_q;

    // EX producer beats MEM producer; an EX load is handled by the load-use bubble instead.
    always_comb begin
        fwd_a_d = FWD_NONE;
        fwd_b_d = FWD_NONE;
        if (hit_ex_a && !ex_e.load) fwd_a_d = FWD_EXMEM;
        else if (hit_mem_a)         fwd_a_d = FWD_MEMWB;
        if (hit_ex_b && !ex_e.load) fwd_b_d = FWD_EXMEM;
        else if (hit_mem_b)         fwd_b_d = FWD_MEMWB;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fwd_a_q <= FWD_NONE;
            fwd_b_q <= FWD_NONE;
        end else if (!freeze) begin
            fwd_a_q <= bubble ? FWD_NONE : fwd_a_d;
            fwd_b_q <= bubble ? FWD_NONE : fwd_b_d;
        end
    end

    assign fwd_a_sel_o = fwd_a_q;
    assign fwd_b_sel_o = fwd_b_q;
`else
    assign fwd_a_sel_o = FWD_NONE;
    assign fwd_b_sel_o = FWD_NONE;
`endif

    hazard_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    // Counter value equals the number of wait cycles completed so far, saturating.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        case (state_q)
            HZ_RUN: begin
                if (freeze) begin
                    state_d = HZ_WAIT_MEM;
                    cnt_d   = CNT_W'(1);
                end
            end
            HZ_WAIT_MEM: begin
                if (!freeze)
                    state_d = HZ_RUN;
                else if (cnt_q != CNT_W'(MEM_TIMEOUT))
                    cnt_d = cnt_q + CNT_W'(1);
            end
            default: state_d = HZ_RUN;
        endcase
        if (freeze && cnt_d == CNT_W'(MEM_TIMEOUT))
            timeout_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= HZ_RUN;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign mem_timeout_o = timeout_q;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage riscv_cpu core (IF/ID/EX/MEM/WB).
- Consumes the decoded control of the instruction in ID: source/dest registers, reg_we, load (WDATA_MEM), mem_we, jal_op.
- Tracks in-flight destinations in a shadow scoreboard (EX/MEM/WB).
- Drives PC/pipeline-register stall and flush enables, and registered forwarding selects for the EX operand muxes.

Parameters:
- ADDR_WIDTH, 5, register address width (from riscv_cpu_pkg).
- MEM_TIMEOUT, 255, maximum consecutive data-memory wait cycles before timeout is flagged.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- id_valid_i  in  1  ID holds a real instruction.
- id_rs1_i  in  ADDR_WIDTH  ID source register 1.
- id_rs2_i  in  ADDR_WIDTH  ID source register 2.
- id_rs1_used_i  in  1  rs1 is read.
- id_rs2_used_i  in  1  rs2 is read.
- id_rd_i  in  ADDR_WIDTH  ID destination register.
- id_reg_we_i  in  1  ID instruction writes rd (includes JAL/JALR).
- id_load_i  in  1  ID instruction is a load.
- ex_redirect_i  in  1  taken branch or jump resolved in EX this cycle.
- mem_req_i  in  1  MEM stage performs a data access.
- mem_ready_i  in  1  data memory completes the access this cycle.
- pc_stall_o  out  1  hold PC.
- if_id_stall_o  out  1  hold IF/ID register.
- if_id_flush_o  out  1  clear IF/ID to NOP.
- id_ex_flush_o  out  1  insert bubble into ID/EX.
- pipe_freeze_o  out  1  hold ID/EX, EX/MEM, MEM/WB.
- fwd_a_sel_o  out  2  EX operand A source.
- fwd_b_sel_o  out  2  EX operand B source.
- mem_timeout_o  out  1  sticky timeout flag.

Behaviour:
- Reset (async, rst_ni=0):
  - Scoreboard entries invalid; FSM = RUN; wait counter = 0.
  - fwd_*_sel_o = FWD_NONE; mem_timeout_o = 0.
  - All stall/flush outputs therefore 0.
- Scoreboard:
  - Three entries {valid, rd, we, load} for EX, MEM and WB.
  - Advance when not frozen: WB<=MEM, MEM<=EX, EX<=ID info, or invalid if a bubble/flush is inserted.
  - While frozen, all entries hold.
- Hazard match: the entry is valid & we & rd!=0 & rd==rs, and the corresponding rs_used is 1.
- The register file is write-through, so the WB entry never causes a hazard.
- Priority, highest first:
  1. freeze — mem_req_i & !mem_ready_i.
  2. redirect — ex_redirect_i.
  3. load-use stall.
- Freeze:
  - pipe_freeze_o = pc_stall_o = if_id_stall_o = 1; both flush outputs = 0.
  - A coincident redirect is deferred; EX holds, so ex_redirect_i stays asserted.
- Redirect:
  - if_id_flush_o = id_ex_flush_o = 1 for exactly that cycle; stalls = 0.
  - The two younger instructions are killed; EX entry loaded invalid.
- Load-use:
  - The ID instruction matches the EX entry with load=1.
  - pc_stall_o = if_id_stall_o = id_ex_flush_o = 1 for one cycle; EX entry loaded invalid.
- Forwarding:
  - Computed from ID vs EX/MEM entries.
  - Registered on advance; held when frozen; cleared to FWD_NONE when a bubble is inserted.
  - Encoding: FWD_NONE=0, FWD_EXMEM=1 (match EX entry, non-load), FWD_MEMWB=2 (match MEM entry, any).
  - The EX entry has priority over the MEM entry.
  - An EX-entry load match never forwards; it triggers load-use instead.
- FSM, states RUN and WAIT_MEM:
  - RUN -> WAIT_MEM when mem_req_i & !mem_ready_i; counter reset to 1.
  - WAIT_MEM: counter increments, saturating at MEM_TIMEOUT.
  - WAIT_MEM -> RUN on mem_ready_i.
  - When the counter reaches MEM_TIMEOUT, mem_timeout_o is set and stays set until reset.
  - The freeze continues regardless of timeout.
- id_valid_i=0: no load-use or RAW stall raised; ID info enters EX as invalid.

Optional Feature:
- Macro: HAZARD_CTRL_FWD_EN.
- Defined:
  - Forwarding as above; only load-use stalls.
- Undefined:
  - fwd_*_sel_o tied to FWD_NONE.
  - Any RAW match against the EX or MEM entry stalls like load-use: 1 bubble per cycle until the producer reaches WB.
  - Worst case is 2 bubbles.

Decomposition:
- riscv_cpu_pkg gains:
  - FWD_SEL_WIDTH=2.
  - Constants FWD_NONE, FWD_EXMEM, FWD_MEMWB.
  - hazard_state_e {HZ_RUN, HZ_WAIT_MEM}.
  - sb_entry_t packed struct {valid, rd, we, load}.
- One sub-module, hazard_scoreboard: three-entry shift register with freeze and bubble inputs.
- hazard_ctrl keeps the comparators, priority logic and FSM.

Test Plan:
- Load-use:
  - Stimulus: lw x5 in EX (EX entry load, rd=5); ID add with rs1=5.
  - Response: exactly one cycle of pc_stall_o=if_id_stall_o=id_ex_flush_o=1.
  - The next advance registers fwd_a_sel_o=FWD_MEMWB.
- EX forwarding:
  - Stimulus: addi x3 in EX; ID sub with rs2=3.
  - Response: no stall; fwd_b_sel_o=FWD_EXMEM.
  - If the MEM entry also has rd=3, FWD_EXMEM still wins.
- x0 and unused operands:
  - Stimulus: EX entry rd=0 load; ID rs1=0. Separately, a match on rs2 with id_rs2_used_i=0.
  - Response: no stall, FWD_NONE.
- Redirect vs load-use:
  - Stimulus: ex_redirect_i=1 in the same cycle as a load-use match.
  - Response: both flushes 1, pc_stall_o=0; next cycle no stall.
- Memory wait and timeout:
  - Stimulus: mem_req_i=1, mem_ready_i=0 for 300 cycles with MEM_TIMEOUT=255.
  - Response: freeze for all 300 cycles; mem_timeout_o rises on wait cycle 255 and stays high.
  - mem_ready_i=1 returns the FSM to RUN; the flag is cleared only by rst_ni.
- Reset and no-forwarding build:
  - Stimulus: assert rst_ni=0 mid-freeze.
  - Response: all outputs 0 immediately.
  - With HAZARD_CTRL_FWD_EN undefined, a back-to-back dependent add gives 2 bubbles.
